// File: rtl/icb_dma_mst_pkg.sv
// Shared constants, widths and state encoding for the ICB DMA initiator.
package icb_dma_mst_pkg;

  localparam int unsigned ADR_STEP_DEF = 4;
  localparam int unsigned ADR_W        = 20;
  localparam int unsigned DAT_W        = 32;
  localparam int unsigned LEN_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } dma_state_e;

  // Byte address advance; wraps modulo 2^ADR_W by truncation.
  function automatic logic [ADR_W-1:0] adr_next(input logic [ADR_W-1:0] adr,
                                                input int unsigned      step);
    return adr + ADR_W'(step);
  endfunction

endpackage

// File: rtl/icb_tmo_cnt.sv
// Per-request timeout counter: cleared by load, counts while en is high and
// flags expiry on the TMO_CYC-th counted cycle.
module icb_tmo_cnt #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST_CNT = 16'(TMO_CYC - 1);

  logic [15:0] cnt_r;

  // cycles spent so far in the current request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 16'd0;
    end else if (load) begin
      cnt_r <= 16'd0;
    end else if (en && !expire) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/icb_dma_mst.sv
// ICB DMA initiator: copies len 32-bit words from src_adr to dst_adr with a
// single outstanding read or write request and a per-request timeout.
module icb_dma_mst
  import icb_dma_mst_pkg::*;
#(
  parameter int unsigned TMO_CYC  = 255,
  parameter int unsigned ADR_STEP = ADR_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADR_W-1:0]  src_adr,
  input  logic [ADR_W-1:0]  dst_adr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_left,
  output logic              icb_wr,
  output logic [ADR_W-1:0]  icb_wadr,
  output logic [DAT_W-1:0]  icb_wdat,
  input  logic              icb_wack,
  output logic              icb_rd,
  output logic [ADR_W-1:0]  icb_radr,
  input  logic [DAT_W-1:0]  icb_rdat,
  input  logic              icb_rack
);

  dma_state_e        state_r, state_s;
  logic              act_r, act_s;
  logic              rd_r, rd_s;
  logic              wr_r, wr_s;
  logic              busy_r, done_r;
  logic              err_r, err_s;
  logic [LEN_W-1:0]  left_r, left_s;
  logic [ADR_W-1:0]  radr_r, radr_s;
  logic [ADR_W-1:0]  wadr_r, wadr_s;
  logic [DAT_W-1:0]  hold_r, hold_s;
  logic              tmo_load_s;
  logic              tmo_expire_s;

  icb_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (tmo_load_s),
    .en     (act_r),
    .expire (tmo_expire_s)
  );

  // Each RD/WR visit spends its first cycle with the request low (act_r=0),
  // which guarantees the idle gap between consecutive requests.
  always_comb begin
    state_s    = state_r;
    act_s      = act_r;
    rd_s       = rd_r;
    wr_s       = wr_r;
    err_s      = err_r;
    left_s     = left_r;
    radr_s     = radr_r;
    wadr_s     = wadr_r;
    hold_s     = hold_r;
    tmo_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          err_s  = 1'b0;
          radr_s = src_adr;
          wadr_s = dst_adr;
          left_s = len;
          act_s  = 1'b0;
          if (len != 16'd0) begin
            state_s = ST_RD;
          end else begin
            state_s = ST_FIN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (!act_r) begin
          rd_s       = 1'b1;
          act_s      = 1'b1;
          tmo_load_s = 1'b1;
        end else if (icb_rack) begin
          hold_s  = icb_rdat;
          rd_s    = 1'b0;
          act_s   = 1'b0;
          state_s = ST_WR;
        end else if (tmo_expire_s) begin
          rd_s    = 1'b0;
          act_s   = 1'b0;
          err_s   = 1'b1;
          state_s = ST_FIN;
        end else begin
          rd_s = 1'b1;
        end
      end
      ST_WR: begin
        if (!act_r) begin
          wr_s       = 1'b1;
          act_s      = 1'b1;
          tmo_load_s = 1'b1;
        end else if (icb_wack) begin
          wr_s   = 1'b0;
          act_s  = 1'b0;
          radr_s = adr_next(radr_r, ADR_STEP);
          wadr_s = adr_next(wadr_r, ADR_STEP);
          left_s = left_r - 16'd1;
          if ((left_r == 16'd1) || abort) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_RD;
          end
        end else if (tmo_expire_s) begin
          wr_s    = 1'b0;
          act_s   = 1'b0;
          err_s   = 1'b1;
          state_s = ST_FIN;
        end else begin
          wr_s = 1'b1;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        act_s   = 1'b0;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
      end
    endcase
  end

  // state and registered outputs; done trails FIN so it lands in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      act_r   <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      left_r  <= 16'd0;
      radr_r  <= 20'd0;
      wadr_r  <= 20'd0;
      hold_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      act_r   <= act_s;
      rd_r    <= rd_s;
      wr_r    <= wr_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_r == ST_FIN);
      err_r   <= err_s;
      left_r  <= left_s;
      radr_r  <= radr_s;
      wadr_r  <= wadr_s;
      hold_r  <= hold_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign words_left = left_r;
  assign icb_rd     = rd_r;
  assign icb_radr   = radr_r;
  assign icb_wr     = wr_r;
  assign icb_wadr   = wadr_r;
  assign icb_wdat   = hold_r;

endmodule

// File: tb/tb_icb_dma_mst.sv
// Bench for icb_dma_mst: directed and random copies predicted by a
// transaction-level model, checked by a scoreboard monitor on the ICB ports.
module tb_icb_dma_mst;

  localparam int unsigned TMO  = 8;
  localparam int unsigned STEP = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [19:0] src_adr;
  logic [19:0] dst_adr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_left;
  logic        icb_wr;
  logic [19:0] icb_wadr;
  logic [31:0] icb_wdat;
  logic        icb_wack;
  logic        icb_rd;
  logic [19:0] icb_radr;
  logic [31:0] icb_rdat;
  logic        icb_rack;

  int n_chk  = 0;
  int n_pass = 0;

  logic [19:0] exp_rd[$];
  logic [51:0] exp_wr[$];
  logic [16:0] exp_done[$];

  int          fixed_dly = 0;
  bit          dead_en   = 1'b0;
  bit          spur_en   = 1'b0;
  logic [19:0] dead_adr  = 20'd0;

  icb_dma_mst #(
    .TMO_CYC  (TMO),
    .ADR_STEP (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .src_adr    (src_adr),
    .dst_adr    (dst_adr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_left (words_left),
    .icb_wr     (icb_wr),
    .icb_wadr   (icb_wadr),
    .icb_wdat   (icb_wdat),
    .icb_wack   (icb_wack),
    .icb_rd     (icb_rd),
    .icb_radr   (icb_radr),
    .icb_rdat   (icb_rdat),
    .icb_rack   (icb_rack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endfunction

  // Contents of the simulated memory behind the responder.
  function automatic logic [31:0] mem_word(input logic [19:0] a);
    logic [31:0] x;
    x = {12'h000, a};
    return (x * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: the transactions one copy must produce.
  task automatic plan_copy(input logic [19:0] src, input logic [19:0] dst, input logic [15:0] l,
                           input bit dead, input logic [19:0] dadr, input int abort_k);
    int          n;
    bit          hit;
    logic [19:0] ra;
    logic [19:0] wa;
    n   = int'(l);
    hit = 1'b0;
    if (abort_k >= 0 && abort_k < n) n = abort_k + 1;
    for (int i = 0; i < n; i++) begin
      ra = src + 20'(i * STEP);
      wa = dst + 20'(i * STEP);
      exp_rd.push_back(ra);
      if (dead && ra == dadr) begin
        hit = 1'b1;
        exp_done.push_back({1'b1, 16'(int'(l) - i)});
        break;
      end
      exp_wr.push_back({wa, mem_word(ra)});
    end
    if (!hit) exp_done.push_back({1'b0, 16'(int'(l) - n)});
  endtask

  // Responder: acks after a per-request delay, never acks the dead address,
  // and throws stray acks while no request is up.
  initial begin
    int rcnt;
    int wcnt;
    int rdly;
    int wdly;
    rcnt = 0; wcnt = 0; rdly = 1; wdly = 1;
    icb_rack = 1'b0; icb_wack = 1'b0; icb_rdat = 32'd0;
    forever begin
      @(posedge clk); #1;
      icb_rack = 1'b0;
      icb_wack = 1'b0;
      if (!rst) begin
        rcnt = 0;
        wcnt = 0;
      end else begin
        if (icb_rd) begin
          rcnt++;
          if (rcnt == 1) rdly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 4));
          if (rcnt == rdly && !(dead_en && icb_radr == dead_adr)) begin
            icb_rack = 1'b1;
            icb_rdat = mem_word(icb_radr);
          end
        end else begin
          rcnt = 0;
        end
        if (icb_wr) begin
          wcnt++;
          if (wcnt == 1) wdly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 4));
          if (wcnt == wdly) icb_wack = 1'b1;
        end else begin
          wcnt = 0;
        end
        if (!icb_rd && !icb_wr && spur_en && $urandom_range(0, 2) == 0) begin
          icb_rack = 1'($urandom_range(0, 1));
          icb_wack = ~icb_rack;
          icb_rdat = $urandom;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic        rd_prev = 1'b0, wr_prev = 1'b0, done_prev = 1'b0;
  logic        rd_acked = 1'b0, wr_acked = 1'b0;
  int          rd_len = 0, wr_len = 0;
  logic [19:0] rd_hold = 20'd0, wr_hold = 20'd0;
  logic [31:0] wd_hold = 32'd0;
  logic [51:0] we;
  logic [16:0] de;

  always @(negedge clk) begin
    if (!rst) begin
      rd_prev = 1'b0; wr_prev = 1'b0; done_prev = 1'b0;
    end else begin
      chk("rd_wr_exclusive", 64'(icb_rd & icb_wr), 64'd0);
      if (icb_rd && !rd_prev) begin
        chk("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) chk("rd_adr", 64'(icb_radr), 64'(exp_rd.pop_front()));
        rd_len = 1; rd_hold = icb_radr; rd_acked = icb_rack;
      end else if (icb_rd) begin
        rd_len++;
        chk("rd_adr_stable", 64'(icb_radr), 64'(rd_hold));
        if (icb_rack) rd_acked = 1'b1;
      end else if (rd_prev && !rd_acked) begin
        chk("rd_tmo_len", 64'(rd_len), 64'(TMO));
      end
      if (icb_wr && !wr_prev) begin
        chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          we = exp_wr.pop_front();
          chk("wr_adr", 64'(icb_wadr), 64'(we[51:32]));
          chk("wr_dat", 64'(icb_wdat), 64'(we[31:0]));
        end
        wr_len = 1; wr_hold = icb_wadr; wd_hold = icb_wdat; wr_acked = icb_wack;
      end else if (icb_wr) begin
        wr_len++;
        chk("wr_adr_stable", 64'(icb_wadr), 64'(wr_hold));
        chk("wr_dat_stable", 64'(icb_wdat), 64'(wd_hold));
        if (icb_wack) wr_acked = 1'b1;
      end else if (wr_prev && !wr_acked) begin
        chk("wr_tmo_len", 64'(wr_len), 64'(TMO));
      end
      if (done) begin
        chk("done_width", 64'(done_prev), 64'd0);
        chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0) begin
          de = exp_done.pop_front();
          chk("done_err", 64'(err), 64'(de[16]));
          chk("done_words_left", 64'(words_left), 64'(de[15:0]));
          chk("done_busy", 64'(busy), 64'd0);
        end
      end
      rd_prev = icb_rd; wr_prev = icb_wr; done_prev = done;
    end
  end

  task automatic run_copy(input logic [19:0] s, input logic [19:0] d, input logic [15:0] l,
                          input int dly, input bit dead, input logic [19:0] dadr,
                          input int abort_k, input bit poke);
    int rises;
    int busy_cyc;
    int done_at;
    bit got;
    bit prev_rd;
    fixed_dly = dly; dead_en = dead; dead_adr = dadr;
    plan_copy(s, d, l, dead, dadr, abort_k);
    @(posedge clk); #2;
    src_adr = s; dst_adr = d; len = l; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; src_adr = 20'($urandom); dst_adr = 20'($urandom); len = 16'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err), 64'd0);
    chk("words_left_load", 64'(words_left), 64'(l));
    rises = 0; prev_rd = 1'b0; busy_cyc = 1; got = 1'b0; done_at = -1;
    for (int c = 1; c < 400 && !got; c++) begin
      @(posedge clk); #2;
      if (icb_rd && !prev_rd) rises++;
      prev_rd = icb_rd;
      if (abort_k >= 0 && rises == abort_k + 1 && icb_rd) abort = 1'b1;
      if (poke && c == 3 && busy) begin
        start = 1'b1; len = 16'd0;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
      if (done) begin
        got = 1'b1; done_at = c;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    abort = 1'b0;
    if (l == 16'd0) begin
      chk("len0_done_delay", 64'(done_at), 64'd1);
      chk("len0_busy_cycles", 64'(busy_cyc), 64'd1);
    end
    if (dead) begin
      @(posedge clk); #2;
      chk("err_sticky", 64'(err), 64'd1);
    end
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask

  initial begin
    bit          seen;
    logic [15:0] rl;
    logic [19:0] rs;
    int          ak;
    bit          dd;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    src_adr = 20'd0; dst_adr = 20'd0; len = 16'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_words_left", 64'(words_left), 64'd0);
    chk("rst_icb_rd", 64'(icb_rd), 64'd0);
    chk("rst_icb_wr", 64'(icb_wr), 64'd0);
    chk("rst_radr", 64'(icb_radr), 64'd0);
    chk("rst_wadr", 64'(icb_wadr), 64'd0);
    chk("rst_wdat", 64'(icb_wdat), 64'd0);
    rst = 1'b1;
    spur_en = 1'b1;
    repeat (2) @(posedge clk);

    run_copy(20'h00100, 20'h00200, 16'd3, 2, 1'b0, 20'd0, -1, 1'b0);
    run_copy(20'h00500, 20'h00600, 16'd0, 0, 1'b0, 20'd0, -1, 1'b0);
    run_copy(20'h30000, 20'h31000, 16'd3, 2, 1'b1, 20'h30000, -1, 1'b0);
    run_copy(20'h00400, 20'h00800, 16'd4, 0, 1'b0, 20'd0, 1, 1'b0);
    run_copy(20'hFFFFC, 20'h10000, 16'd2, 0, 1'b0, 20'd0, -1, 1'b0);

    // reset while a write is outstanding
    fixed_dly = 3; dead_en = 1'b0;
    plan_copy(20'h01000, 20'h02000, 16'd5, 1'b0, 20'd0, -1);
    @(posedge clk); #2;
    src_adr = 20'h01000; dst_adr = 20'h02000; len = 16'd5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #2;
      if (icb_wr) seen = 1'b1;
    end
    chk("wr_before_rst", 64'(icb_wr), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_icb_wr", 64'(icb_wr), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_words_left", 64'(words_left), 64'd0);
    exp_rd.delete(); exp_wr.delete(); exp_done.delete();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      chk("rst_mid_no_done", 64'(done), 64'd0);
    end
    rst = 1'b1;
    run_copy(20'h04000, 20'h05000, 16'd3, 0, 1'b0, 20'd0, -1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      rs = 20'($urandom) & 20'hFFFFC;
      rl = 16'($urandom_range(1, 6));
      ak = -1; dd = 1'b0;
      if ($urandom_range(0, 3) == 0) ak = int'($urandom_range(0, int'(rl) - 1));
      else if ($urandom_range(0, 4) == 0) dd = 1'b1;
      run_copy(rs, 20'($urandom) & 20'hFFFFC, rl, 0, dd,
               rs + 20'(STEP * $urandom_range(0, int'(rl) - 1)), ak, 1'b1);
    end

    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/icb_dma_mst.md
ICB_DMA_MST -- requirements
Module: icb_dma_mst

Interface
REQ-001 Parameter TMO_CYC, default 255: cycles without acknowledge before a request is abandoned (1..65535).
REQ-002 Parameter ADR_STEP, default 4: byte increment applied to source and destination addresses per word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 abort  input  1  level request to stop after the current bus handshake completes.
REQ-007 src_adr  input  20  first read byte address, captured on accepted start.
REQ-008 dst_adr  input  20  first write byte address, captured on accepted start.
REQ-009 len  input  16  number of 32-bit words to copy, captured on accepted start.
REQ-010 busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-011 done  output  1  one-cycle pulse on completion, abort or error.
REQ-012 err  output  1  sticky timeout flag, cleared on the next accepted start.
REQ-013 words_left  output  16  remaining word count.
REQ-014 icb_wr/icb_wadr[19:0]/icb_wdat[31:0]  output  write request, address, data; icb_wack input 1 write acknowledge.
REQ-015 icb_rd/icb_radr[19:0]  output  read request, address; icb_rdat[31:0] input read data; icb_rack input 1 read acknowledge.

Function
REQ-016 States SHALL be IDLE, RD, WR, FIN; one-hot or binary encoding per the shared header.
REQ-017 IDLE: start=1 and len!=0 -> RD next cycle; start=1 and len=0 -> FIN without any bus request; start while busy SHALL be ignored.
REQ-018 RD: icb_rd SHALL be held high with icb_radr stable until icb_rack is sampled high; icb_rdat SHALL be captured into a 32-bit hold register that same cycle; next state WR.
REQ-019 WR: icb_wr SHALL be held high with icb_wadr and icb_wdat (hold register) stable until icb_wack is sampled high; then the addresses SHALL advance by ADR_STEP and words_left SHALL decrement.
REQ-020 After a WR acknowledge: words_left becomes 0 or abort=1 -> FIN; otherwise -> RD; icb_wr and icb_rd SHALL be low for at least one cycle between consecutive requests.
REQ-021 icb_rd and icb_wr SHALL never be high in the same cycle.
REQ-022 Acknowledge arriving on the first request cycle SHALL be accepted (minimum 2 cycles per RD or WR).
REQ-023 A per-request cycle counter SHALL reset on each request start; reaching TMO_CYC with no ack SHALL drop the request, set err and go to FIN.
REQ-024 Acknowledges received outside an active request SHALL be ignored.
REQ-025 Abort seen during RD SHALL still complete the paired WR before entering FIN (no data loss).
REQ-026 FIN: done=1 for exactly one cycle, then IDLE; busy low in IDLE.
REQ-027 Address arithmetic SHALL be modulo 2^20 (wraps 0xFFFFC -> 0x00000 with ADR_STEP 4).
REQ-028 Outputs icb_radr/icb_wadr/icb_wdat SHALL be registered; value outside an active request is don't-care but SHALL not change during one.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, busy=0, done=0, err=0, words_left=0, icb_wr=0, icb_rd=0, addresses and hold register to 0.
REQ-030 Reset during an active request SHALL drop the request immediately; no done pulse is produced.

Structure
REQ-031 State encodings and the ADR_STEP default SHALL live in the shared address/constant include file used by the peripheral region.
REQ-032 One sub-module, icb_tmo_cnt (loadable timeout counter with expire flag), is natural; everything else stays in icb_dma_mst.
REQ-033 The block SHALL connect to the peripheral region as an alternate initiator; no arbitration logic lives inside it.

Verification
REQ-034 len=3, src 0x00100, dst 0x00200, responder acks on 2nd cycle -> reads 0x00100/104/108, writes 0x00200/204/208 with matching data, done one pulse, err=0.
REQ-035 len=0 with start -> no icb_rd/icb_wr, done pulses 2 cycles after start, busy high 1 cycle.
REQ-036 Read to unmapped address (no rack), TMO_CYC=8 -> icb_rd dropped after 8 cycles, err=1, done pulse, no write issued.
REQ-037 len=4, abort raised during 2nd RD -> 2nd WR completes, done pulses, words_left=2, no 3rd read.
REQ-038 src=0xFFFFC, len=2 -> second read address 0x00000.
REQ-039 rst low while icb_wr high -> icb_wr low immediately, busy=0, no done; subsequent start works normally.
